// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: in-order writeback has priority, and long-latency
// results wait in a small FIFO until a free cycle. Pending FIFO destinations are reported to the hazard unit.
module rf_write_arbiter #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = 32,
    parameter int unsigned AW    = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_en,
    input  logic [AW-1:0]              wb_dest,
    input  logic [DW-1:0]              wb_val,
    input  logic                       lu_valid,
    input  logic [AW-1:0]              lu_dest,
    input  logic [DW-1:0]              lu_val,
    output logic                       lu_ready,
    output logic                       rf_we,
    output logic [AW-1:0]              rf_dest,
    output logic [DW-1:0]              rf_val,
    input  logic [AW-1:0]              pend_src1,
    input  logic [AW-1:0]              pend_src2,
    output logic                       pend_hit1,
    output logic                       pend_hit2,
    output logic [$clog2(DEPTH+1)-1:0] fifo_count
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] dest;
        logic [DW-1:0] val;
    } entry_t;

    entry_t        entries_q [DEPTH];
    entry_t        entries_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          rf_we_q, rf_we_d;
    logic [AW-1:0] rf_dest_q, rf_dest_d;
    logic [DW-1:0] rf_val_q, rf_val_d;

    logic wb_fire;
    logic push;
    logic pop;

    // Writes to r0 are architecturally void, so they never consume the port or a FIFO slot.
    assign wb_fire  = wb_en && (wb_dest != '0);
    assign lu_ready = !rst && (count_q < CW'(DEPTH));
    assign push     = lu_valid && lu_ready && (lu_dest != '0);
    assign pop      = !wb_fire && (count_q != '0);

    assign rf_we      = rf_we_q;
    assign rf_dest    = rf_dest_q;
    assign rf_val     = rf_val_q;
    assign fifo_count = count_q;

    // Next-state: port selection, WAW kill, push and pop.
    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        rf_we_d   = 1'b0;
        rf_dest_d = rf_dest_q;
        rf_val_d  = rf_val_q;

        if (wb_fire) begin
            rf_we_d   = 1'b1;
            rf_dest_d = wb_dest;
            rf_val_d  = wb_val;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (entries_q[PW'(i)].dest == wb_dest) begin
                    entries_d[PW'(i)].valid = 1'b0;
                end
            end
        end else if (pop) begin
            rf_we_d                = entries_q[head_q].valid;
            rf_dest_d              = entries_q[head_q].dest;
            rf_val_d               = entries_q[head_q].val;
            entries_d[head_q].valid = 1'b0;
            head_d                 = head_q + PW'(1);
        end

        // A result for a register the pipeline writes this same cycle is already stale.
        if (push) begin
            entries_d[tail_q].valid = !(wb_fire && (lu_dest == wb_dest));
            entries_d[tail_q].dest  = lu_dest;
            entries_d[tail_q].val   = lu_val;
            tail_d                  = tail_q + PW'(1);
        end

        count_d = count_q + CW'(push) - CW'(pop);
    end

    // Hazard query: only live entries still in the FIFO count as pending.
    always_comb begin
        pend_hit1 = 1'b0;
        pend_hit2 = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (entries_q[PW'(i)].valid && (entries_q[PW'(i)].dest == pend_src1)) begin
                pend_hit1 = 1'b1;
            end
            if (entries_q[PW'(i)].valid && (entries_q[PW'(i)].dest == pend_src2)) begin
                pend_hit2 = 1'b1;
            end
        end
        if (pend_src1 == '0) begin
            pend_hit1 = 1'b0;
        end
        if (pend_src2 == '0) begin
            pend_hit2 = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entries_q <= '{default: '0};
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            rf_we_q   <= 1'b0;
            rf_dest_q <= '0;
            rf_val_q  <= '0;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            rf_we_q   <= rf_we_d;
            rf_dest_q <= rf_dest_d;
            rf_val_q  <= rf_val_d;
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Randomized bench for rf_write_arbiter against a queue-based model of the write-port rules.
module tb_rf_write_arbiter;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_dest = '0;
    logic [31:0] wb_val = '0;
    logic        lu_valid = 1'b0;
    logic [4:0]  lu_dest = '0;
    logic [31:0] lu_val = '0;
    logic        lu_ready;
    logic        rf_we;
    logic [4:0]  rf_dest;
    logic [31:0] rf_val;
    logic [4:0]  pend_src1 = '0;
    logic [4:0]  pend_src2 = '0;
    logic        pend_hit1;
    logic        pend_hit2;
    logic [2:0]  fifo_count;

    rf_write_arbiter #(.DEPTH(DEPTH), .DW(32), .AW(5)) dut (
        .clk(clk), .rst(rst),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_val(wb_val),
        .lu_valid(lu_valid), .lu_dest(lu_dest), .lu_val(lu_val), .lu_ready(lu_ready),
        .rf_we(rf_we), .rf_dest(rf_dest), .rf_val(rf_val),
        .pend_src1(pend_src1), .pend_src2(pend_src2),
        .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, want, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model: the FIFO is an ordered list of results; killed ones keep their place.
    typedef struct {
        bit        v;
        bit [4:0]  d;
        bit [31:0] val;
    } ment_t;

    ment_t     mq[$];
    bit        exp_we   = 1'b0;
    bit [4:0]  exp_dest = '0;
    bit [31:0] exp_val  = '0;

    function automatic bit exp_hit(input bit [4:0] s);
        if (s == 0) return 1'b0;
        foreach (mq[i]) if (mq[i].v && mq[i].d == s) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_step(input bit ready);
        bit    fire;
        ment_t e;
        fire = wb_en && (wb_dest != 0);
        if (fire) begin
            exp_we = 1'b1; exp_dest = wb_dest; exp_val = wb_val;
            foreach (mq[i]) if (mq[i].d == wb_dest) mq[i].v = 1'b0;
        end else if (mq.size() > 0) begin
            e = mq.pop_front();
            exp_we = e.v; exp_dest = e.d; exp_val = e.val;
        end else begin
            exp_we = 1'b0;
        end
        if (lu_valid && ready && lu_dest != 0) begin
            e.v = !(fire && lu_dest == wb_dest);
            e.d = lu_dest;
            e.val = lu_val;
            mq.push_back(e);
        end
    endtask

    task automatic do_cycle(input bit we, input bit [4:0] wd, input bit [31:0] wv,
                            input bit lv, input bit [4:0] ld, input bit [31:0] lvv,
                            input bit [4:0] s1, input bit [4:0] s2);
        bit ready;
        @(negedge clk);
        wb_en = we; wb_dest = wd; wb_val = wv;
        lu_valid = lv; lu_dest = ld; lu_val = lvv;
        pend_src1 = s1; pend_src2 = s2;
        #1;
        ready = (mq.size() < DEPTH);
        check("lu_ready", lu_ready, ready);
        check("pend_hit1", pend_hit1, exp_hit(s1));
        check("pend_hit2", pend_hit2, exp_hit(s2));
        @(posedge clk);
        model_step(ready);
        #1;
        check("rf_we", rf_we, exp_we);
        check("rf_dest", rf_dest, exp_dest);
        check("rf_val", rf_val, exp_val);
        check("fifo_count", fifo_count, mq.size());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rf_we"}, rf_we, 0);
        check({tag, "_rf_dest"}, rf_dest, 0);
        check({tag, "_rf_val"}, rf_val, 0);
        check({tag, "_count"}, fifo_count, 0);
        check({tag, "_lu_ready"}, lu_ready, 0);
        check({tag, "_hit1"}, pend_hit1, 0);
        check({tag, "_hit2"}, pend_hit2, 0);
    endtask

    // Reset asserted between edges, with a handshake attempted while it is held.
    task automatic mid_reset(input bit [4:0] s1, input bit [4:0] s2);
        @(negedge clk);
        wb_en = 1'b0; lu_valid = 1'b1; lu_dest = 5'd9; lu_val = 32'h99;
        pend_src1 = s1; pend_src2 = s2;
        #2 rst = 1'b1;
        #1;
        mq.delete();
        exp_we = 1'b0; exp_dest = '0; exp_val = '0;
        check_reset_outputs("rst_async");
        @(posedge clk); #1;
        check_reset_outputs("rst_held");
        @(negedge clk);
        rst = 1'b0; lu_valid = 1'b0;
        #1;
        check("rst_rel_lu_ready", lu_ready, 1);
        check("rst_rel_count", fifo_count, 0);
    endtask

    initial begin
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("por");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("por_rel_lu_ready", lu_ready, 1);

        // Pipeline-only writes, including the ignored r0 write.
        do_cycle(1, 7, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        do_cycle(1, 0, 32'h12345678, 0, 0, 0, 0, 0);

        // Fill while the pipeline owns the port; a fifth result must wait.
        for (int k = 0; k < 4; k++)
            do_cycle(1, 3, 32'h300 + k, 1, 5'(8 + k), 32'h800 + k, 5'(8 + k), 5'd11);
        do_cycle(1, 3, 32'h304, 1, 12, 32'h80C, 8, 12);
        for (int k = 0; k < 4; k++)
            do_cycle(0, 0, 0, 0, 0, 0, 5'(8 + k), 5'd11);

        // WAW kill: buffered r5 is superseded by a younger pipeline write.
        do_cycle(1, 3, 32'h33, 1, 5, 32'h11, 5, 0);
        do_cycle(1, 5, 32'h22, 0, 0, 0, 5, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 5, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 5, 0);

        // Hazard query on a buffered r12, then its drain.
        do_cycle(1, 3, 32'h1, 1, 12, 32'hC, 12, 0);
        do_cycle(1, 4, 32'h2, 0, 0, 0, 12, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 12, 0);
        do_cycle(0, 0, 0, 0, 0, 0, 12, 0);

        // Simultaneous push and pop at count 2, then an r0 handshake.
        do_cycle(1, 3, 32'h1, 1, 13, 32'hD, 13, 14);
        do_cycle(1, 3, 32'h2, 1, 14, 32'hE, 13, 14);
        do_cycle(0, 0, 0, 1, 15, 32'hF, 13, 15);
        do_cycle(1, 3, 32'h3, 1, 0, 32'hAA, 14, 15);
        repeat (3) do_cycle(0, 0, 0, 0, 0, 0, 14, 15);

        // Reset with three results buffered.
        for (int k = 0; k < 3; k++)
            do_cycle(1, 3, 32'h40 + k, 1, 5'(20 + k), 32'h900 + k, 0, 0);
        mid_reset(20, 21);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                mid_reset(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
            end else begin
                do_cycle($urandom_range(0, 99) < 45, 5'($urandom_range(0, 15)), $urandom,
                         $urandom_range(0, 99) < 60, 5'($urandom_range(0, 15)), $urandom,
                         5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
